gpio_pad_conditioner: RTL and testbench
=======================================

Name: gpio_pad_conditioner

Overview:
- Sits between the pad-ring input data (we_din/no_din/ea_din/so_din GPIO bits, concatenated) and zerosoc gpio_i.
- Per bit, it synchronises the asynchronous pad input, optionally debounces it, and detects edges.
- It keeps sticky edge-status bits that the SoC clears by writing 1s.
- Pad pins without an enabled input buffer hold their last filtered value, so floating inputs cannot generate edges.

Parameters:
- Width, 32, number of GPIO bits conditioned.
- SyncStages, 2, synchroniser flop count; legal values >= 2.
- DebounceCycles, 4, consecutive mismatching synced cycles required to accept a change; legal values >= 1.
- CntW, $clog2(DebounceCycles+1), debounce counter width; derived, not overridable.

Ports:
- clk_i  input  1  core clock.
- rst_ni  input  1  asynchronous active-low reset.
- pad_din_i  input  Width  raw pad input data, asynchronous to clk_i.
- pad_ie_i  input  Width  per-bit input-buffer enable (1 = input buffer enabled).
- db_en_i  input  Width  per-bit debounce enable, quasi-static.
- status_clr_i  input  Width  write-1-to-clear strobe for status_o, one cycle.
- gpio_o  output  Width  conditioned level, drives zerosoc gpio_i.
- rise_o  output  Width  one-cycle pulse on each 0->1 change of gpio_o.
- fall_o  output  Width  one-cycle pulse on each 1->0 change of gpio_o.
- status_o  output  Width  sticky "any edge seen" bits.

Behaviour:
- Reset (async assert, sync deassert by the system): all sync flops, gpio_o, debounce counters, prev-level regs and status_o go to 0. rise_o and fall_o are therefore 0.
- Sync: pad_din_i passes through a SyncStages-deep flop chain. No other logic sees pad_din_i. sync_q is the last stage.
- Input gating: when pad_ie_i[i]=0:
  - the stable register for bit i holds;
  - cnt[i] is forced to 0;
  - no edges are produced.
- Debounce path, when db_en_i[i]=1 and pad_ie_i[i]=1:
  - if sync_q[i]==gpio_o[i]: cnt[i] <= 0.
  - else if cnt[i]==DebounceCycles-1: gpio_o[i] <= sync_q[i] and cnt[i] <= 0.
  - else: cnt[i] <= cnt[i]+1.
  - Any mismatch run shorter than DebounceCycles cycles is rejected.
- Bypass path, when db_en_i[i]=0 and pad_ie_i[i]=1: gpio_o[i] <= sync_q[i] every cycle, and cnt[i] <= 0. Clearing db_en_i mid-count discards the count.
- Latency from a pad change captured at edge 0:
  - debounce enabled: gpio_o changes after SyncStages+DebounceCycles edges;
  - bypass: gpio_o changes after SyncStages+1 edges.
- Edges: prev_q <= gpio_o each cycle.
  - rise_o = gpio_o & ~prev_q and fall_o = ~gpio_o & prev_q.
  - Both are high in the first cycle gpio_o shows the new value, for exactly one cycle.
- Status update: status_o[i] <= (status_o[i] & ~status_clr_i[i]) | rise_o[i] | fall_o[i]. Set wins over a simultaneous clear.
- DebounceCycles=1 behaves identically to bypass. This is allowed.
- Bits are fully independent and share no state.

Decomposition:
- Package gpio_pad_pkg holds:
  - default constants GpioWidth=32, GpioSyncStages=2, GpioDebounceCycles=4;
  - the pad bit-allocation constants GpioWestLsb=0, GpioNorthLsb=5, GpioEastLsb=14, GpioSouthLsb=23.
- Sub-module gpio_debounce_bit holds the single-bit sync chain, counter, stable register, prev register and status bit. The top level instantiates it Width times in a generate loop and only concatenates the vectors.

Test Plan:
1. Reset and settle. Hold rst_ni=0 with pad_din_i=32'hFFFF_FFFF, then release; pad_ie_i=all 1, db_en_i=all 1.
   -> gpio_o=0 during reset; gpio_o=32'hFFFF_FFFF exactly 2+4=6 edges after release; rise_o=32'hFFFF_FFFF for 1 cycle; status_o=32'hFFFF_FFFF.
2. Glitch reject. Bit 3 debounced; a 3-cycle high pulse on pad_din_i[3], synchronous to clk_i.
   -> gpio_o[3] stays 0 and rise_o[3]/status_o[3] stay 0. A 4-cycle pulse -> gpio_o[3]=1 for 4 cycles, rise_o[3] then fall_o[3] pulse, status_o[3]=1.
3. Bypass. db_en_i[7]=0; pad_din_i[7] 0->1.
   -> gpio_o[7]=1 after 3 edges; rise_o[7] high for exactly 1 cycle.
4. Input gating. pad_ie_i[12]=0 with gpio_o[12]=1; toggle pad_din_i[12] for 20 cycles.
   -> gpio_o[12] holds 1; no rise/fall pulses. Re-enable with pad at 0 -> gpio_o[12]=0 after 4 cycles of the sync output.
5. Status clear race. status_o[20]=1. Pulse status_clr_i[20] alone -> status_o[20]=0 next cycle. Pulse status_clr_i[20] in the same cycle as rise_o[20] -> status_o[20] stays 1.
6. Reset mid-count. Bit 25 at cnt=2 with a mismatch pending; assert rst_ni low for 1 cycle.
   -> gpio_o[25]=0 and status_o=0 immediately; after release, the change needs the full 6 edges again.

Source files
------------

// File: rtl/gpio_pad_pkg.sv
// rtl/gpio_pad_pkg.sv - shared constants for the GPIO pad input conditioner
package gpio_pad_pkg;

  // Default build of the conditioner
  localparam int GpioWidth          = 32;
  localparam int GpioSyncStages     = 2;
  localparam int GpioDebounceCycles = 4;

  // Where each pad-ring side lands in the concatenated GPIO vector
  localparam int GpioWestLsb  = 0;
  localparam int GpioNorthLsb = 5;
  localparam int GpioEastLsb  = 14;
  localparam int GpioSouthLsb = 23;

  // Counter width able to hold 0..cycles
  function automatic int gpio_cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// rtl/gpio_debounce_bit.sv - one GPIO bit: synchroniser, debounce, edge detect, sticky status
module gpio_debounce_bit
  import gpio_pad_pkg::*;
#(
  parameter int SyncStages     = GpioSyncStages,
  parameter int DebounceCycles = GpioDebounceCycles
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pad_din_i,
  input  logic pad_ie_i,
  input  logic db_en_i,
  input  logic status_clr_i,
  output logic gpio_o,
  output logic rise_o,
  output logic fall_o,
  output logic status_o
);

  localparam int CntW = gpio_cnt_width(DebounceCycles);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

  logic [SyncStages-1:0] sync_q;
  logic                  sync_out;
  logic [CntW-1:0]       cnt_q;
  logic                  stable_q;
  logic                  prev_q;
  logic                  status_q;

  assign sync_out = sync_q[SyncStages-1];

  // Synchroniser chain: the only consumer of the raw pad input
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], pad_din_i};
    end
  end

  // Stable level: held while the input buffer is off, filtered or passed through otherwise
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else if (!pad_ie_i) begin
      cnt_q <= '0;
    end else if (!db_en_i) begin
      stable_q <= sync_out;
      cnt_q    <= '0;
    end else if (sync_out == stable_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CntLast) begin
      stable_q <= sync_out;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // Previous level for edge detection and sticky status (a new edge beats a clear)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q   <= 1'b0;
      status_q <= 1'b0;
    end else begin
      prev_q   <= stable_q;
      status_q <= (status_q & ~status_clr_i) | rise_o | fall_o;
    end
  end

  assign gpio_o   = stable_q;
  assign rise_o   = stable_q & ~prev_q;
  assign fall_o   = ~stable_q & prev_q;
  assign status_o = status_q;

endmodule

// File: rtl/gpio_pad_conditioner.sv
// rtl/gpio_pad_conditioner.sv - per-bit conditioning of pad-ring GPIO inputs toward gpio_i
module gpio_pad_conditioner
  import gpio_pad_pkg::*;
#(
  parameter int Width          = GpioWidth,
  parameter int SyncStages     = GpioSyncStages,
  parameter int DebounceCycles = GpioDebounceCycles
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] pad_din_i,
  input  logic [Width-1:0] pad_ie_i,
  input  logic [Width-1:0] db_en_i,
  input  logic [Width-1:0] status_clr_i,
  output logic [Width-1:0] gpio_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output logic [Width-1:0] status_o
);

  // Bits are independent; the top only fans the vectors out and back in
  for (genvar i = 0; i < Width; i++) begin : g_bit
    gpio_debounce_bit #(
      .SyncStages    (SyncStages),
      .DebounceCycles(DebounceCycles)
    ) u_bit (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .pad_din_i   (pad_din_i[i]),
      .pad_ie_i    (pad_ie_i[i]),
      .db_en_i     (db_en_i[i]),
      .status_clr_i(status_clr_i[i]),
      .gpio_o      (gpio_o[i]),
      .rise_o      (rise_o[i]),
      .fall_o      (fall_o[i]),
      .status_o    (status_o[i])
    );
  end

endmodule

// File: tb/tb_gpio_pad_conditioner.sv
// tb/tb_gpio_pad_conditioner.sv - directed scoreboard bench for gpio_pad_conditioner
module tb_gpio_pad_conditioner;

  logic        clk_i;
  logic        rst_ni;
  logic [31:0] pad_din_i;
  logic [31:0] pad_ie_i;
  logic [31:0] db_en_i;
  logic [31:0] status_clr_i;
  logic [31:0] gpio_o;
  logic [31:0] rise_o;
  logic [31:0] fall_o;
  logic [31:0] status_o;

  int tests_run;
  int tests_failed;

  typedef struct {
    string       tag;
    logic [31:0] mask;
    logic [31:0] gpio;
    logic [31:0] rise;
    logic [31:0] fall;
    logic [31:0] status;
  } exp_t;

  exp_t sb[$];

  gpio_pad_conditioner dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .pad_din_i   (pad_din_i),
    .pad_ie_i    (pad_ie_i),
    .db_en_i     (db_en_i),
    .status_clr_i(status_clr_i),
    .gpio_o      (gpio_o),
    .rise_o      (rise_o),
    .fall_o      (fall_o),
    .status_o    (status_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic push_all(input string tag, input logic [31:0] g, input logic [31:0] r,
                          input logic [31:0] f, input logic [31:0] s);
    exp_t e;
    e.tag = tag; e.mask = 32'hFFFF_FFFF;
    e.gpio = g; e.rise = r; e.fall = f; e.status = s;
    sb.push_back(e);
  endtask

  task automatic push_bit(input string tag, input int idx, input logic g, input logic r,
                          input logic f, input logic s);
    exp_t e;
    e.tag = tag; e.mask = 32'h1 << idx;
    e.gpio = {32{g}}; e.rise = {32{r}}; e.fall = {32{f}}; e.status = {32{s}};
    sb.push_back(e);
  endtask

  task automatic cmp(input string tag, input string field, input logic [31:0] obs,
                     input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, expv);
    end
  endtask

  task automatic check_pop();
    exp_t e;
    tests_run++;
    assert (sb.size() != 0) else begin
      tests_failed++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    cmp(e.tag, "gpio",   gpio_o   & e.mask, e.gpio   & e.mask);
    cmp(e.tag, "rise",   rise_o   & e.mask, e.rise   & e.mask);
    cmp(e.tag, "fall",   fall_o   & e.mask, e.fall   & e.mask);
    cmp(e.tag, "status", status_o & e.mask, e.status & e.mask);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_ni       = 1'b0;
    pad_din_i    = 32'hFFFF_FFFF;
    pad_ie_i     = 32'hFFFF_FFFF;
    db_en_i      = 32'hFFFF_FFFF;
    status_clr_i = 32'h0;

    // 1. reset and settle: 6 edges after release
    step(3);
    push_all("reset", 32'h0, 32'h0, 32'h0, 32'h0);
    check_pop();
    rst_ni = 1'b1;
    for (int s = 1; s <= 7; s++) begin
      push_all("settle", (s >= 6) ? 32'hFFFF_FFFF : 32'h0, (s == 6) ? 32'hFFFF_FFFF : 32'h0,
               32'h0, (s >= 7) ? 32'hFFFF_FFFF : 32'h0);
      step(1);
      check_pop();
    end
    status_clr_i = 32'hFFFF_FFFF;
    push_all("settle_clr", 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0);
    step(1);
    status_clr_i = 32'h0;
    check_pop();
    pad_din_i = 32'h0;
    push_all("all_low", 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF);
    step(10);
    check_pop();
    status_clr_i = 32'hFFFF_FFFF;
    step(1);
    status_clr_i = 32'h0;

    // 2. glitch reject (3 cycles) then accept (4 cycles) on bit 3
    pad_din_i[3] = 1'b1;
    for (int s = 1; s <= 12; s++) begin
      if (s == 4) pad_din_i[3] = 1'b0;
      push_bit("glitch3", 3, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1);
      check_pop();
    end
    pad_din_i[3] = 1'b1;
    for (int s = 1; s <= 12; s++) begin
      if (s == 5) pad_din_i[3] = 1'b0;
      push_bit("pulse4", 3, (s >= 6 && s <= 9), (s == 6), (s == 10), (s >= 7));
      step(1);
      check_pop();
    end

    // 3. bypass on bit 7: 3 edges
    db_en_i[7]   = 1'b0;
    pad_din_i[7] = 1'b1;
    for (int s = 1; s <= 5; s++) begin
      push_bit("bypass7", 7, (s >= 3), (s == 3), 1'b0, (s >= 4));
      step(1);
      check_pop();
    end

    // 4. input gating on bit 12
    pad_din_i[12] = 1'b1;
    push_bit("gate_pre", 12, 1'b1, 1'b0, 1'b0, 1'b1);
    step(8);
    check_pop();
    status_clr_i = 32'hFFFF_FFFF;
    step(1);
    status_clr_i = 32'h0;
    pad_ie_i[12] = 1'b0;
    for (int s = 1; s <= 20; s++) begin
      pad_din_i[12] = ~pad_din_i[12];
      push_bit("gated12", 12, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1);
      check_pop();
    end
    pad_din_i[12] = 1'b0;
    step(3);
    pad_ie_i[12] = 1'b1;
    for (int s = 1; s <= 5; s++) begin
      push_bit("reenable12", 12, (s < 4), 1'b0, (s == 4), (s >= 5));
      step(1);
      check_pop();
    end
    status_clr_i = 32'hFFFF_FFFF;
    step(1);
    status_clr_i = 32'h0;

    // 5. status clear alone, then clear racing a rise on bit 20
    pad_din_i[20] = 1'b1;
    for (int s = 1; s <= 7; s++) begin
      push_bit("rise20", 20, (s >= 6), (s == 6), 1'b0, (s >= 7));
      step(1);
      check_pop();
    end
    status_clr_i[20] = 1'b1;
    push_bit("clr20", 20, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1);
    status_clr_i[20] = 1'b0;
    check_pop();
    pad_din_i[20] = 1'b0;
    push_bit("fall20", 20, 1'b0, 1'b0, 1'b0, 1'b1);
    step(7);
    check_pop();
    pad_din_i[20] = 1'b1;
    push_bit("race_rise20", 20, 1'b1, 1'b1, 1'b0, 1'b1);
    step(6);
    check_pop();
    status_clr_i[20] = 1'b1;
    push_bit("race20", 20, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1);
    status_clr_i[20] = 1'b0;
    check_pop();

    // 6. reset while bit 25 is mid-count
    pad_din_i[25] = 1'b1;
    push_bit("midcount25", 25, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4);
    check_pop();
    rst_ni = 1'b0;
    #1;
    push_all("async_reset", 32'h0, 32'h0, 32'h0, 32'h0);
    check_pop();
    step(1);
    rst_ni = 1'b1;
    for (int s = 1; s <= 6; s++) begin
      push_bit("rerun25", 25, (s >= 6), (s == 6), 1'b0, 1'b0);
      step(1);
      check_pop();
    end

    tests_run++;
    assert (sb.size() == 0) else begin
      tests_failed++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
